lfsr_checker: RTL

Receive-side companion to the AFU's LFSR generator. It takes a stream of sampled n-bit LFSR words and self-synchronises to the stream using a software-programmed Galois polynomial. Once locked, it predicts each next word, counts mismatches and samples, and drops lock after persistent errors. It sits on the same W/A/D register bus as the generator and receives the generator's Q (or a looped-back copy) as its data input.

---
 rtl/lfsr_checker.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for a Galois LFSR stream: hunts for a seed, confirms
// LOCK_CNT consecutive predictions, then flywheels and counts errors/samples.
module lfsr_checker #(
  parameter int n        = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         W,
  input  logic [15:0]  A,
  input  logic [n-1:0] D,
  input  logic         in_valid,
  input  logic [n-1:0] in_data,
  output logic [n-1:0] Poly,
  output logic         locked,
  output logic [15:0]  err_count,
  output logic [15:0]  sample_count
);

  localparam logic [15:0] ADDR_POLY = 16'h0020;
  localparam logic [15:0] ADDR_CTRL = 16'h0022;
  localparam logic [3:0]  LOCK_TGT  = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_TGT  = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    SYNC   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  function automatic logic [n-1:0] lfsr_next(input logic [n-1:0] x, input logic [n-1:0] p);
    return (x >> 1) ^ (p & {n{x[0]}});
  endfunction

  state_t      state_r, state_s, fsm_state_s;
  logic [n-1:0] poly_r, pred_r, pred_s;
  logic        enable_r, locked_r;
  logic [3:0]  match_cnt_r, match_s, miss_cnt_r, miss_s;
  logic [15:0] err_r, err_s, err_inc_s, smp_r, smp_s, smp_inc_s;
  logic        poly_wr_s, ctrl_wr_s, sample_ok_s, hit_s;

  // Next-state, prediction and counter logic
  always_comb begin
    poly_wr_s   = W && (A == ADDR_POLY);
    ctrl_wr_s   = W && (A == ADDR_CTRL);
    // A disable or a re-hunting POLY write swallows any sample on the same edge.
    sample_ok_s = in_valid && !(ctrl_wr_s && !D[0]) && !(poly_wr_s && enable_r);
    hit_s       = (in_data == pred_r);
    fsm_state_s = state_r;
    pred_s      = pred_r;
    match_s     = match_cnt_r;
    miss_s      = miss_cnt_r;
    err_inc_s   = err_r;
    smp_inc_s   = smp_r;

    case (state_r)
      IDLE: begin
        if (enable_r) fsm_state_s = HUNT;
        else          fsm_state_s = IDLE;
      end
      HUNT: begin
        if (sample_ok_s && (in_data != '0)) begin
          pred_s      = lfsr_next(in_data, poly_r);
          match_s     = 4'd0;
          fsm_state_s = SYNC;
        end else begin
          fsm_state_s = HUNT;
        end
      end
      SYNC: begin
        if (sample_ok_s) begin
          pred_s = lfsr_next(in_data, poly_r);
          if (hit_s) begin
            match_s = match_cnt_r + 4'd1;
            if (match_s == LOCK_TGT) begin
              fsm_state_s = LOCKED;
              miss_s      = 4'd0;
            end else begin
              fsm_state_s = SYNC;
            end
          end else begin
            match_s = 4'd0;
            if (in_data == '0) fsm_state_s = HUNT;
            else               fsm_state_s = SYNC;
          end
        end else begin
          fsm_state_s = SYNC;
        end
      end
      LOCKED: begin
        if (sample_ok_s) begin
          // Flywheel: predict from our own sequence, not the received word.
          pred_s    = lfsr_next(pred_r, poly_r);
          smp_inc_s = (smp_r == 16'hFFFF) ? smp_r : smp_r + 16'd1;
          if (hit_s) begin
            miss_s      = 4'd0;
            fsm_state_s = LOCKED;
          end else begin
            err_inc_s = (err_r == 16'hFFFF) ? err_r : err_r + 16'd1;
            miss_s    = miss_cnt_r + 4'd1;
            if (miss_s == LOSS_TGT) fsm_state_s = HUNT;
            else                    fsm_state_s = LOCKED;
          end
        end else begin
          fsm_state_s = LOCKED;
        end
      end
      default: fsm_state_s = IDLE;
    endcase

    if (ctrl_wr_s && !D[0]) begin
      state_s = IDLE;
    end else if (poly_wr_s && enable_r) begin
      state_s = HUNT;
      match_s = 4'd0;
      miss_s  = 4'd0;
    end else begin
      state_s = fsm_state_s;
    end

    if (ctrl_wr_s && D[1]) begin
      err_s = 16'd0;
      smp_s = 16'd0;
    end else begin
      err_s = err_inc_s;
      smp_s = smp_inc_s;
    end
  end

  // State, datapath and register-bus storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      poly_r      <= '0;
      pred_r      <= '0;
      enable_r    <= 1'b0;
      match_cnt_r <= 4'd0;
      miss_cnt_r  <= 4'd0;
      err_r       <= 16'd0;
      smp_r       <= 16'd0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      poly_r      <= poly_wr_s ? D : poly_r;
      pred_r      <= pred_s;
      enable_r    <= ctrl_wr_s ? D[0] : enable_r;
      match_cnt_r <= match_s;
      miss_cnt_r  <= miss_s;
      err_r       <= err_s;
      smp_r       <= smp_s;
      locked_r    <= (state_s == LOCKED);
    end
  end

  assign Poly         = poly_r;
  assign locked       = locked_r;
  assign err_count    = err_r;
  assign sample_count = smp_r;

endmodule
